ttt_multichannel_processor: RTL and testbench

Next-generation tick-tock-token processor holding NUM_CHANNELS independent token channels in one register file. Each channel has good/bad token counters, thresholds, a token duration and a countdown. Host instructions address one channel. Tally and countdown are broadcast operations: an FSM sweeps all channels, one per cycle, and emits per-channel start/stop events through a valid/ready handshake. The block sits under the TinyTapeout top wrapper in place of the single-channel processor.

---
 rtl/ttt_pkg.sv | 66 ++++++
 rtl/ttt_multichannel_processor_if.sv | 30 +++
 rtl/ttt_channel_update.sv | 36 +++
 rtl/ttt_multichannel_processor.sv | 168 ++++++++++++++++
 tb/tb_ttt_multichannel_processor.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// Shared types for the multichannel tick-tock-token processor: opcodes, FSM states,
// the per-channel record, and the saturating/threshold arithmetic helpers.
package ttt_pkg;
    localparam int NUM_CHANNELS     = 4;
    localparam int CHANNEL_BITS     = $clog2(NUM_CHANNELS);
    localparam int NEW_TOKEN_BITS   = 8;
    localparam int TOKEN_BITS       = 8;
    localparam int DURATION_BITS    = 8;
    localparam int DATA_BITS        = 8;
    localparam int INSTRUCTION_BITS = 4;
    localparam int SUM_BITS         = TOKEN_BITS + NEW_TOKEN_BITS;

    typedef enum logic [INSTRUCTION_BITS-1:0] {
        OP_ADD_GOOD      = 4'b0000,
        OP_ADD_BAD       = 4'b0001,
        OP_SET_GOOD      = 4'b0010,
        OP_GET_GOOD      = 4'b0011,
        OP_SET_BAD       = 4'b0100,
        OP_GET_BAD       = 4'b0101,
        OP_SET_REMAINING = 4'b0110,
        OP_GET_REMAINING = 4'b0111,
        OP_TALLY         = 4'b1000,
        OP_COUNTDOWN     = 4'b1001,
        OP_SET_GOOD_THR  = 4'b1010,
        OP_GET_GOOD_THR  = 4'b1011,
        OP_SET_BAD_THR   = 4'b1100,
        OP_GET_BAD_THR   = 4'b1101,
        OP_SET_DURATION  = 4'b1110,
        OP_GET_DURATION  = 4'b1111
    } op_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_EMIT} state_t;

    typedef struct packed {
        logic [TOKEN_BITS-1:0]    good;
        logic [TOKEN_BITS-1:0]    bad;
        logic [DURATION_BITS-1:0] remaining;
        logic [TOKEN_BITS-1:0]    good_thr;
        logic [TOKEN_BITS-1:0]    bad_thr;
        logic [DURATION_BITS-1:0] duration;
    } chan_t;

    // Signed counter plus signed increment, clamped to the counter's range.
    function automatic logic [TOKEN_BITS-1:0] sat_add(input logic [TOKEN_BITS-1:0]     cnt,
                                                      input logic [NEW_TOKEN_BITS-1:0] inc);
        logic signed [SUM_BITS-1:0] sum;
        logic signed [SUM_BITS-1:0] hi;
        logic signed [SUM_BITS-1:0] lo;
        hi  = SUM_BITS'((1 << (TOKEN_BITS - 1)) - 1);
        lo  = ~hi;
        sum = $signed({{NEW_TOKEN_BITS{cnt[TOKEN_BITS-1]}}, cnt})
            + $signed({{TOKEN_BITS{inc[NEW_TOKEN_BITS-1]}}, inc});
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end
        return sum[TOKEN_BITS-1:0];
    endfunction

    // Signed counter against an unsigned threshold.
    function automatic logic ge_thr(input logic [TOKEN_BITS-1:0] cnt,
                                    input logic [TOKEN_BITS-1:0] thr);
        return $signed({cnt[TOKEN_BITS-1], cnt}) >= $signed({1'b0, thr});
    endfunction
endpackage

// File: rtl/ttt_multichannel_processor_if.sv
// Host instruction port and event stream of the multichannel processor.
interface ttt_multichannel_processor_if;
    import ttt_pkg::*;

    logic                        instr_valid;
    logic                        instr_ready;
    logic [INSTRUCTION_BITS-1:0] instruction;
    logic [CHANNEL_BITS-1:0]     channel;
    logic [DATA_BITS-1:0]        data_in;
    logic [DATA_BITS-1:0]        data_out;
    logic                        data_valid;
    logic                        event_valid;
    logic                        event_ready;
    logic [CHANNEL_BITS-1:0]     event_channel;
    logic                        event_start;
    logic                        event_stop;
    logic                        busy;

    modport master (
        output instr_valid, instruction, channel, data_in, event_ready,
        input  instr_ready, data_out, data_valid, event_valid, event_channel,
               event_start, event_stop, busy
    );

    modport slave (
        input  instr_valid, instruction, channel, data_in, event_ready,
        output instr_ready, data_out, data_valid, event_valid, event_channel,
               event_start, event_stop, busy
    );
endinterface

// File: rtl/ttt_channel_update.sv
// Combinational tally/countdown step for one channel record, flagging start/stop.
module ttt_channel_update
    import ttt_pkg::*;
(
    input  chan_t rec_i,
    input  logic  tally_i,
    output chan_t rec_o,
    output logic  start_o,
    output logic  stop_o
);
    logic is_on;

    always_comb begin
        rec_o   = rec_i;
        start_o = 1'b0;
        stop_o  = 1'b0;
        is_on   = (rec_i.remaining != '0);
        if (tally_i) begin
            if (!is_on && ge_thr(rec_i.good, rec_i.good_thr) && !ge_thr(rec_i.bad, rec_i.bad_thr)) begin
                start_o         = 1'b1;
                stop_o          = (rec_i.duration == '0);
                rec_o.remaining = rec_i.duration;
                rec_o.good      = '0;
                rec_o.bad       = '0;
            end else if (is_on && ge_thr(rec_i.bad, rec_i.bad_thr)) begin
                stop_o          = 1'b1;
                rec_o.remaining = '0;
                rec_o.good      = '0;
                rec_o.bad       = '0;
            end
        end else if (is_on) begin
            rec_o.remaining = rec_i.remaining - DURATION_BITS'(1);
            stop_o          = (rec_i.remaining == DURATION_BITS'(1));
        end
    end
endmodule

// File: rtl/ttt_multichannel_processor.sv
// Multichannel token processor: single-cycle per-channel host ops, plus tally/countdown
// sweeps that visit one channel per cycle and park in EMIT until each event is accepted.
module ttt_multichannel_processor
    import ttt_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic enable,
    ttt_multichannel_processor_if.slave bus
);
    localparam logic [CHANNEL_BITS-1:0] LAST_CH = CHANNEL_BITS'(NUM_CHANNELS - 1);

    state_t                  state_q, state_d;
    logic [CHANNEL_BITS-1:0] idx_q, idx_d;
    logic                    tally_q, tally_d;
    chan_t                   ch_q [NUM_CHANNELS];
    chan_t                   ch_d [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    ev_vld_q, ev_vld_d;
    logic [CHANNEL_BITS-1:0] ev_ch_q, ev_ch_d;
    logic                    ev_start_q, ev_start_d;
    logic                    ev_stop_q, ev_stop_d;

    op_t   op;
    chan_t cur;
    chan_t upd_in;
    chan_t upd_rec;
    logic  upd_start;
    logic  upd_stop;

    assign upd_in = ch_q[idx_q];

    ttt_channel_update u_update (
        .rec_i   (upd_in),
        .tally_i (tally_q),
        .rec_o   (upd_rec),
        .start_o (upd_start),
        .stop_o  (upd_stop)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tally_d      = tally_q;
        ch_d         = ch_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        ev_vld_d     = ev_vld_q;
        ev_ch_d      = ev_ch_q;
        ev_start_d   = ev_start_q;
        ev_stop_d    = ev_stop_q;
        op           = op_t'(bus.instruction);
        cur          = ch_q[bus.channel];
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    data_valid_d = 1'b1;
                    case (op)
                        OP_ADD_GOOD: begin
                            cur.good   = sat_add(cur.good, bus.data_in[NEW_TOKEN_BITS-1:0]);
                            data_out_d = DATA_BITS'(cur.good);
                        end
                        OP_ADD_BAD: begin
                            cur.bad    = sat_add(cur.bad, bus.data_in[NEW_TOKEN_BITS-1:0]);
                            data_out_d = DATA_BITS'(cur.bad);
                        end
                        OP_SET_GOOD: begin
                            cur.good   = bus.data_in[TOKEN_BITS-1:0];
                            data_out_d = DATA_BITS'(cur.good);
                        end
                        OP_GET_GOOD:      data_out_d = DATA_BITS'(cur.good);
                        OP_SET_BAD: begin
                            cur.bad    = bus.data_in[TOKEN_BITS-1:0];
                            data_out_d = DATA_BITS'(cur.bad);
                        end
                        OP_GET_BAD:       data_out_d = DATA_BITS'(cur.bad);
                        OP_SET_REMAINING: begin
                            cur.remaining = bus.data_in[DURATION_BITS-1:0];
                            data_out_d    = DATA_BITS'(cur.remaining);
                        end
                        OP_GET_REMAINING: data_out_d = DATA_BITS'(cur.remaining);
                        OP_SET_GOOD_THR: begin
                            cur.good_thr = bus.data_in[TOKEN_BITS-1:0];
                            data_out_d   = DATA_BITS'(cur.good_thr);
                        end
                        OP_GET_GOOD_THR:  data_out_d = DATA_BITS'(cur.good_thr);
                        OP_SET_BAD_THR: begin
                            cur.bad_thr = bus.data_in[TOKEN_BITS-1:0];
                            data_out_d  = DATA_BITS'(cur.bad_thr);
                        end
                        OP_GET_BAD_THR:   data_out_d = DATA_BITS'(cur.bad_thr);
                        OP_SET_DURATION: begin
                            cur.duration = bus.data_in[DURATION_BITS-1:0];
                            data_out_d   = DATA_BITS'(cur.duration);
                        end
                        OP_GET_DURATION:  data_out_d = DATA_BITS'(cur.duration);
                        default: begin
                            data_valid_d = 1'b0;
                            tally_d      = (op == OP_TALLY);
                            idx_d        = '0;
                            state_d      = ST_SWEEP;
                        end
                    endcase
                    ch_d[bus.channel] = cur;
                end
            end
            ST_SWEEP: begin
                ch_d[idx_q] = upd_rec;
                if (upd_start || upd_stop) begin
                    ev_vld_d   = 1'b1;
                    ev_ch_d    = idx_q;
                    ev_start_d = upd_start;
                    ev_stop_d  = upd_stop;
                    state_d    = ST_EMIT;
                end else if (idx_q == LAST_CH) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + CHANNEL_BITS'(1);
                end
            end
            ST_EMIT: begin
                if (bus.event_ready) begin
                    ev_vld_d = 1'b0;
                    idx_d    = idx_q + CHANNEL_BITS'(1);
                    state_d  = (idx_q == LAST_CH) ? ST_IDLE : ST_SWEEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // enable gates every register, so a frozen cycle leaves the handshakes untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            tally_q      <= 1'b0;
            ch_q         <= '{default: '0};
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            ev_vld_q     <= 1'b0;
            ev_ch_q      <= '0;
            ev_start_q   <= 1'b0;
            ev_stop_q    <= 1'b0;
        end else if (enable) begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tally_q      <= tally_d;
            ch_q         <= ch_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            ev_vld_q     <= ev_vld_d;
            ev_ch_q      <= ev_ch_d;
            ev_start_q   <= ev_start_d;
            ev_stop_q    <= ev_stop_d;
        end
    end

    assign bus.instr_ready   = (state_q == ST_IDLE);
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.data_out      = data_out_q;
    assign bus.data_valid    = data_valid_q;
    assign bus.event_valid   = ev_vld_q;
    assign bus.event_channel = ev_ch_q;
    assign bus.event_start   = ev_start_q;
    assign bus.event_stop    = ev_stop_q;
endmodule

// File: tb/tb_ttt_multichannel_processor.sv
// Bench for ttt_multichannel_processor: an integer channel model predicts data_out values
// and the ordered event stream; a negedge monitor compares, directed steps pin literals.
module tb_ttt_multichannel_processor;
    import ttt_pkg::*;

    localparam int ADD_GOOD = 0, ADD_BAD = 1, SET_GOOD = 2, GET_GOOD = 3;
    localparam int SET_BAD = 4, GET_BAD = 5, SET_REM = 6, GET_REM = 7;
    localparam int TALLY = 8, COUNTDOWN = 9, SET_GTHR = 10, GET_GTHR = 11;
    localparam int SET_BTHR = 12, GET_BTHR = 13, SET_DUR = 14, GET_DUR = 15;

    logic clock;
    logic reset;
    logic enable;
    ttt_multichannel_processor_if bus();

    ttt_multichannel_processor dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    int m_good [4];
    int m_bad  [4];
    int m_rem  [4];
    int m_gthr [4];
    int m_bthr [4];
    int m_dur  [4];
    int exp_data [$];
    int exp_ev   [$];   // ch*4 + start*2 + stop

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_good[i] = 0; m_bad[i] = 0; m_rem[i] = 0;
            m_gthr[i] = 0; m_bthr[i] = 0; m_dur[i] = 0;
        end
        exp_data.delete();
        exp_ev.delete();
    endtask

    task automatic model_sweep(input bit tally);
        for (int c = 0; c < 4; c++) begin
            if (tally) begin
                if (m_rem[c] == 0 && m_good[c] >= m_gthr[c] && m_bad[c] < m_bthr[c]) begin
                    exp_ev.push_back(c * 4 + 2 + ((m_dur[c] == 0) ? 1 : 0));
                    m_rem[c] = m_dur[c]; m_good[c] = 0; m_bad[c] = 0;
                end else if (m_rem[c] != 0 && m_bad[c] >= m_bthr[c]) begin
                    exp_ev.push_back(c * 4 + 1);
                    m_rem[c] = 0; m_good[c] = 0; m_bad[c] = 0;
                end
            end else if (m_rem[c] > 0) begin
                m_rem[c]--;
                if (m_rem[c] == 0) exp_ev.push_back(c * 4 + 1);
            end
        end
    endtask

    task automatic model_op(input int op, input int ch, input int d);
        int u8;
        int s8;
        u8 = d & 255;
        s8 = (u8 >= 128) ? u8 - 256 : u8;
        case (op)
            ADD_GOOD: begin m_good[ch] = clamp8(m_good[ch] + s8); exp_data.push_back(m_good[ch] & 255); end
            ADD_BAD:  begin m_bad[ch] = clamp8(m_bad[ch] + s8); exp_data.push_back(m_bad[ch] & 255); end
            SET_GOOD: begin m_good[ch] = s8; exp_data.push_back(u8); end
            GET_GOOD: exp_data.push_back(m_good[ch] & 255);
            SET_BAD:  begin m_bad[ch] = s8; exp_data.push_back(u8); end
            GET_BAD:  exp_data.push_back(m_bad[ch] & 255);
            SET_REM:  begin m_rem[ch] = u8; exp_data.push_back(u8); end
            GET_REM:  exp_data.push_back(m_rem[ch]);
            TALLY:    model_sweep(1'b1);
            COUNTDOWN: model_sweep(1'b0);
            SET_GTHR: begin m_gthr[ch] = u8; exp_data.push_back(u8); end
            GET_GTHR: exp_data.push_back(m_gthr[ch]);
            SET_BTHR: begin m_bthr[ch] = u8; exp_data.push_back(u8); end
            GET_BTHR: exp_data.push_back(m_bthr[ch]);
            SET_DUR:  begin m_dur[ch] = u8; exp_data.push_back(u8); end
            default:  exp_data.push_back(m_dur[ch]);
        endcase
    endtask

    // Compare process: every data_valid pulse and every cycle an event is pending.
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.data_valid === 1'b1) begin
                if (exp_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL data_unexpected got %0d expected no pulse", bus.data_out);
                end else begin
                    check("data_out", int'(bus.data_out), exp_data[0]);
                    void'(exp_data.pop_front());
                end
            end
            if (bus.event_valid === 1'b1) begin
                if (exp_ev.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL event_unexpected got ch %0d start %0b stop %0b expected none",
                             bus.event_channel, bus.event_start, bus.event_stop);
                end else begin
                    check("event", int'(bus.event_channel) * 4 + int'(bus.event_start) * 2
                                   + int'(bus.event_stop), exp_ev[0]);
                    if (bus.event_ready && enable) void'(exp_ev.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL idle_timeout busy %0b expected 0", bus.busy);
        end
    endtask

    task automatic wait_event_ch(input int ch);
        int n = 0;
        while (!(bus.event_valid === 1'b1 && int'(bus.event_channel) == ch) && n < 200) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL event_timeout got none expected ch %0d", ch);
        end
    endtask

    task automatic do_op(input int op, input int ch, input int d, input int freeze = 0);
        wait_idle();
        if (freeze > 0) begin
            @(posedge clock); #1;
            enable = 1'b0;
        end
        bus.instr_valid = 1'b1;
        bus.instruction = INSTRUCTION_BITS'(op);
        bus.channel     = CHANNEL_BITS'(ch);
        bus.data_in     = DATA_BITS'(d);
        for (int i = 0; i < freeze; i++) begin
            @(posedge clock); #1;
            check("frozen_data_valid", int'(bus.data_valid), 0);
        end
        enable = 1'b1;
        model_op(op, ch, d);
        @(posedge clock); #1;
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        bus.instr_valid = 1'b0; bus.instruction = '0; bus.channel = '0;
        bus.data_in = '0; bus.event_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1; reset = 1'b0;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_event_valid", int'(bus.event_valid), 0);
        check("rst_data_valid", int'(bus.data_valid), 0);
        check("rst_data_out", int'(bus.data_out), 0);
        check("rst_instr_ready", int'(bus.instr_ready), 1);
        mon_en = 1'b1;

        // Every readable field of every channel starts at zero.
        for (int c = 0; c < 4; c++) begin
            do_op(GET_GOOD, c, 0); do_op(GET_BAD, c, 0); do_op(GET_REM, c, 0);
            do_op(GET_GTHR, c, 0); do_op(GET_BTHR, c, 0); do_op(GET_DUR, c, 0);
        end

        // Channel 2 qualifies for a start of duration 2.
        do_op(SET_GTHR, 2, 3); do_op(SET_BTHR, 2, 2); do_op(SET_DUR, 2, 2);
        do_op(ADD_GOOD, 2, 3);
        do_op(TALLY, 0, 0);
        check("model_rem2", m_rem[2], 2);
        wait_event_ch(2);
        check("tally_ev_start", int'(bus.event_start), 1);
        check("tally_ev_stop", int'(bus.event_stop), 0);
        do_op(GET_REM, 2, 0);
        check("rem2_after_tally", int'(bus.data_out), 2);

        // Countdown 2 -> 1 is silent, 1 -> 0 stops.
        do_op(COUNTDOWN, 0, 0);
        wait_idle();
        do_op(COUNTDOWN, 0, 0);
        wait_event_ch(2);
        check("cd_ev_start", int'(bus.event_start), 0);
        check("cd_ev_stop", int'(bus.event_stop), 1);
        do_op(GET_REM, 2, 0);
        check("rem2_after_cd", int'(bus.data_out), 0);

        // Saturation on channel 1; the first write is presented under a freeze.
        do_op(SET_GOOD, 1, 120, 3);
        check("frozen_then_set", int'(bus.data_out), 120);
        do_op(ADD_GOOD, 1, 20);
        check("sat_hi", int'(bus.data_out), 127);
        check("model_sat_hi", m_good[1], 127);
        do_op(ADD_GOOD, 1, 128);
        check("sat_mid", int'(bus.data_out), 255);
        do_op(ADD_GOOD, 1, 128);
        check("sat_lo", int'(bus.data_out), 128);
        check("model_sat_lo", m_good[1], -128);

        // Channels 0 and 3 qualify; consumer stalls on the first event.
        for (int k = 0; k < 2; k++) begin
            do_op(SET_GTHR, k * 3, 1); do_op(SET_BTHR, k * 3, 1);
            do_op(SET_DUR, k * 3, 3); do_op(ADD_GOOD, k * 3, 1);
        end
        bus.event_ready = 1'b0;
        do_op(TALLY, 0, 0);
        check("model_two_events", exp_ev.size(), 2);
        wait_event_ch(0);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", int'(bus.event_valid), 1);
            check("hold_ch", int'(bus.event_channel), 0);
            check("hold_start", int'(bus.event_start), 1);
            check("hold_instr_ready", int'(bus.instr_ready), 0);
            @(posedge clock); #1;
        end
        bus.event_ready = 1'b1;
        wait_event_ch(3);
        check("second_ev_start", int'(bus.event_start), 1);
        check("second_instr_ready", int'(bus.instr_ready), 0);
        wait_idle();
        check("sweep_done_busy", int'(bus.busy), 0);

        // Zero-duration start, then reset while the event is parked.
        do_op(SET_DUR, 2, 0);
        do_op(ADD_GOOD, 2, 3);
        bus.event_ready = 1'b0;
        do_op(TALLY, 0, 0);
        wait_event_ch(2);
        check("dur0_start", int'(bus.event_start), 1);
        check("dur0_stop", int'(bus.event_stop), 1);
        check("emit_busy", int'(bus.busy), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        bus.event_ready = 1'b1;
        check("rst_emit_event_valid", int'(bus.event_valid), 0);
        check("rst_emit_busy", int'(bus.busy), 0);
        check("rst_emit_instr_ready", int'(bus.instr_ready), 1);
        do_op(GET_DUR, 0, 0);
        check("rst_cleared_dur0", int'(bus.data_out), 0);

        repeat (3) @(posedge clock);
        #1;
        check("data_queue_drained", exp_data.size(), 0);
        check("event_queue_drained", exp_ev.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
